// File: rtl/except_unit_pkg.sv
// Shared constants for the memory-stage exception unit: CP0 register numbers,
// commit codes, Status bit positions and the MTC0 bypass helper.
package except_unit_pkg;

    localparam logic [4:0]  CP0_REG_STATUS = 5'd12;
    localparam logic [4:0]  CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0]  CP0_REG_EPC    = 5'd14;

    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BLOCK = 1'b1;

    typedef struct packed {
        logic adel_if;
        logic ri;
        logic syscall;
        logic brk;
        logic ov;
        logic adel_ld;
        logic ades;
        logic eret;
    } exc_flags_t;

    // Value of a CP0 register as seen this cycle, including an in-flight MTC0.
    function automatic logic [31:0] cp0_bypass(
        input logic        we,
        input logic [4:0]  waddr,
        input logic [4:0]  reg_num,
        input logic [31:0] wdata,
        input logic [31:0] cur
    );
        logic [31:0] val;
        if (we && (waddr == reg_num)) begin
            val = wdata;
        end else begin
            val = cur;
        end
        return val;
    endfunction

endpackage

// File: rtl/except_unit_int_sync.sv
// Two-flop synchronizer for the raw hardware interrupt lines.
module except_unit_int_sync
    import except_unit_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/except_unit.sv
// Memory-stage exception collector: prioritises exceptions and interrupts,
// drives the CP0 commit interface, the pipeline flush and the redirect PC.
module except_unit
    import except_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        stall_i,
    input  logic        inst_valid_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        ov_i,
    input  logic        adel_ld_i,
    input  logic        ades_i,
    input  logic        eret_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    output logic [5:0]  int_sync_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] newpc_o
);

    logic [0:0]  r_state;
    logic        r_int_req;

    logic [31:0] w_status_eff;
    logic [31:0] w_cause_byp;
    logic [31:0] w_cause_eff;
    logic [31:0] w_epc_eff;
    logic        w_int_pend;
    logic        w_commit_ok;
    logic        w_commit;
    logic        w_int_commit;
    logic [31:0] w_code;
    logic [31:0] w_bad;
    exc_flags_t  w_flags;

    except_unit_int_sync #(.WIDTH(6)) u_int_sync (
        .clk (clk),
        .rst (rst),
        .i_d (int_i),
        .o_q (int_sync_o)
    );

    // Only the software-interrupt bits of Cause are writable by MTC0.
    assign w_status_eff = cp0_bypass(cp0_we_i, cp0_waddr_i, CP0_REG_STATUS, cp0_wdata_i, status_i);
    assign w_cause_byp  = cp0_bypass(cp0_we_i, cp0_waddr_i, CP0_REG_CAUSE,  cp0_wdata_i, cause_i);
    assign w_cause_eff  = {cause_i[31:10], w_cause_byp[9:8], cause_i[7:0]};
    assign w_epc_eff    = cp0_bypass(cp0_we_i, cp0_waddr_i, CP0_REG_EPC,    cp0_wdata_i, epc_i);

    assign w_int_pend = (|(w_cause_eff[STATUS_IM_HI:STATUS_IM_LO] & w_status_eff[STATUS_IM_HI:STATUS_IM_LO]))
                      & w_status_eff[STATUS_IE] & ~w_status_eff[STATUS_EXL];

    assign w_flags = '{adel_if: adel_if_i, ri: ri_i, syscall: syscall_i, brk: break_i,
                       ov: ov_i, adel_ld: adel_ld_i, ades: ades_i, eret: eret_i};

    // Fixed-priority exception select; the latched interrupt is re-qualified
    // by the live pending term so a same-cycle MTC0 can still mask it.
    always_comb begin
        w_code = EXC_NONE;
        w_bad  = 32'h0000_0000;
        if (r_int_req && w_int_pend) begin
            w_code = EXC_INT;
        end else if (w_flags.adel_if) begin
            w_code = EXC_ADEL;
            w_bad  = pc_i;
        end else if (w_flags.ri) begin
            w_code = EXC_RI;
        end else if (w_flags.syscall) begin
            w_code = EXC_SYS;
        end else if (w_flags.brk) begin
            w_code = EXC_BP;
        end else if (w_flags.ov) begin
            w_code = EXC_OV;
        end else if (w_flags.adel_ld) begin
            w_code = EXC_ADEL;
            w_bad  = mem_addr_i;
        end else if (w_flags.ades) begin
            w_code = EXC_ADES;
            w_bad  = mem_addr_i;
        end else if (w_flags.eret) begin
            w_code = EXC_ERET;
        end else begin
            w_code = EXC_NONE;
        end
    end

    assign w_commit_ok  = (r_state == ST_IDLE) & ~stall_i & inst_valid_i & ~rst;
    assign w_commit     = w_commit_ok & (w_code != EXC_NONE);
    assign w_int_commit = w_commit & (w_code == EXC_INT);

    // Commit interface toward CP0 and the pipeline redirect.
    always_comb begin
        excepttype_o        = EXC_NONE;
        flush_o             = 1'b0;
        newpc_o             = 32'h0000_0000;
        bad_addr_o          = 32'h0000_0000;
        current_inst_addr_o = 32'h0000_0000;
        is_in_delayslot_o   = 1'b0;
        if (rst) begin
            current_inst_addr_o = 32'h0000_0000;
            is_in_delayslot_o   = 1'b0;
        end else begin
            current_inst_addr_o = pc_i;
            is_in_delayslot_o   = in_delayslot_i;
            if (w_commit) begin
                excepttype_o = w_code;
                flush_o      = 1'b1;
                newpc_o      = (w_code == EXC_ERET) ? w_epc_eff : EXC_VECTOR;
                bad_addr_o   = w_bad;
            end else begin
                excepttype_o = EXC_NONE;
            end
        end
    end

    // Interrupt latch and the one-cycle post-commit blocking FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_int_req <= 1'b0;
        end else begin
            r_int_req <= w_int_pend & ~w_int_commit;
            case (r_state)
                ST_IDLE:  r_state <= w_commit ? ST_BLOCK : ST_IDLE;
                ST_BLOCK: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = ^{w_status_eff[31:16], w_status_eff[7:2], w_cause_eff[31:16], w_cause_eff[7:0]};

endmodule

// File: tb/tb_except_unit.sv
// Directed, table-driven bench for except_unit with a tiny CP0 Cause IP model.
module tb_except_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_i;
    logic        stall_i, inst_valid_i, in_delayslot_i;
    logic [31:0] pc_i, mem_addr_i, status_i, cause_i, epc_i, cp0_wdata_i;
    logic        adel_if_i, ri_i, syscall_i, break_i, ov_i, adel_ld_i, ades_i, eret_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [5:0]  int_sync_o;
    logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;
    logic        is_in_delayslot_o, flush_o;
    logic [5:0]  tb_ip;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // CP0 Cause.IP follows the synchronized lines one cycle later.
    always @(posedge clk) tb_ip <= rst ? 6'h00 : int_sync_o;
    assign cause_i = {16'h0000, tb_ip, 10'h000};

    except_unit dut (
        .clk(clk), .rst(rst), .int_i(int_i), .stall_i(stall_i), .inst_valid_i(inst_valid_i),
        .pc_i(pc_i), .in_delayslot_i(in_delayslot_i), .adel_if_i(adel_if_i), .ri_i(ri_i),
        .syscall_i(syscall_i), .break_i(break_i), .ov_i(ov_i), .adel_ld_i(adel_ld_i),
        .ades_i(ades_i), .eret_i(eret_i), .mem_addr_i(mem_addr_i), .status_i(status_i),
        .cause_i(cause_i), .epc_i(epc_i), .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i),
        .cp0_wdata_i(cp0_wdata_i), .int_sync_o(int_sync_o), .excepttype_o(excepttype_o),
        .current_inst_addr_o(current_inst_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
        .bad_addr_o(bad_addr_o), .flush_o(flush_o), .newpc_o(newpc_o)
    );

    typedef struct {
        logic [7:0]  flags;   // adel_if ri syscall break ov adel_ld ades eret
        logic [31:0] pc;
        logic        ds;
        logic [31:0] maddr;
        logic [31:0] epc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] e_code;
        logic [31:0] e_newpc;
        logic [31:0] e_bad;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clr_in();
        {adel_if_i, ri_i, syscall_i, break_i, ov_i, adel_ld_i, ades_i, eret_i} = 8'h00;
        stall_i        = 1'b0;
        inst_valid_i   = 1'b0;
        in_delayslot_i = 1'b0;
        pc_i           = 32'h8000_0000;
        mem_addr_i     = 32'h0000_0000;
        epc_i          = 32'h0000_0000;
        cp0_we_i       = 1'b0;
        cp0_waddr_i    = 5'd0;
        cp0_wdata_i    = 32'h0000_0000;
    endtask

    task automatic chk_commit(input string name, input logic [31:0] code,
                              input logic [31:0] npc, input logic [31:0] bad);
        chk({name, " code"},  excepttype_o, code);
        chk({name, " flush"}, {31'd0, flush_o}, {31'd0, (code != 32'd0)});
        chk({name, " newpc"}, newpc_o, npc);
        chk({name, " bad"},   bad_addr_o, bad);
    endtask

    initial begin
        vecs[0]  = '{8'b0000_1000, 32'h8000_1000, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0c, 32'hBFC0_0380, 32'h0};
        vecs[1]  = '{8'b0000_0110, 32'h8000_1004, 1'b0, 32'h8000_0003, 32'h0, 1'b0, 5'd0, 32'h0, 32'h04, 32'hBFC0_0380, 32'h8000_0003};
        vecs[2]  = '{8'b0000_0010, 32'h8000_1008, 1'b0, 32'h8000_0010, 32'h0, 1'b0, 5'd0, 32'h0, 32'h05, 32'hBFC0_0380, 32'h8000_0010};
        vecs[3]  = '{8'b1100_0000, 32'h8000_0001, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 5'd0, 32'h0, 32'h04, 32'hBFC0_0380, 32'h8000_0001};
        vecs[4]  = '{8'b0110_0000, 32'h8000_100c, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0a, 32'hBFC0_0380, 32'h0};
        vecs[5]  = '{8'b0011_0000, 32'h8000_1010, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h08, 32'hBFC0_0380, 32'h0};
        vecs[6]  = '{8'b0001_1010, 32'h8000_1014, 1'b0, 32'h8000_0020, 32'h0, 1'b0, 5'd0, 32'h0, 32'h09, 32'hBFC0_0380, 32'h0};
        vecs[7]  = '{8'b0000_0001, 32'h8000_1018, 1'b0, 32'h0, 32'h8000_2000, 1'b1, 5'd14, 32'h8000_3000, 32'h0e, 32'h8000_3000, 32'h0};
        vecs[8]  = '{8'b0000_0001, 32'h8000_101c, 1'b0, 32'h0, 32'h8000_2000, 1'b0, 5'd14, 32'h8000_3000, 32'h0e, 32'h8000_2000, 32'h0};
        vecs[9]  = '{8'b0000_0001, 32'h8000_1020, 1'b0, 32'h0, 32'h8000_2000, 1'b1, 5'd12, 32'h0, 32'h0e, 32'h8000_2000, 32'h0};
        vecs[10] = '{8'b0000_0000, 32'h8000_4000, 1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h00, 32'h0, 32'h0};
        vecs[11] = '{8'b0000_1100, 32'h8000_5000, 1'b1, 32'h8000_0044, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0c, 32'hBFC0_0380, 32'h0};
        vecs[12] = '{8'b0000_0101, 32'h8000_6000, 1'b0, 32'h8000_0008, 32'h8000_2000, 1'b0, 5'd0, 32'h0, 32'h04, 32'hBFC0_0380, 32'h8000_0008};

        // Reset: outputs forced to zero even with an excepting instruction present.
        clr_in();
        rst = 1'b1; int_i = 6'h00; status_i = 32'h0;
        adv(); adv();
        inst_valid_i = 1'b1; ov_i = 1'b1; pc_i = 32'h8000_0100; in_delayslot_i = 1'b1;
        settle();
        chk_commit("reset", 32'h0, 32'h0, 32'h0);
        chk("reset curpc", current_inst_addr_o, 32'h0);
        chk("reset ds", {31'd0, is_in_delayslot_o}, 32'h0);
        chk("reset intsync", {26'd0, int_sync_o}, 32'h0);
        adv();
        rst = 1'b0;
        clr_in();
        adv();

        // Table: one instruction, then a bubble to let the block cycle pass.
        for (int i = 0; i < 13; i++) begin
            clr_in();
            {adel_if_i, ri_i, syscall_i, break_i, ov_i, adel_ld_i, ades_i, eret_i} = vecs[i].flags;
            inst_valid_i = 1'b1;
            pc_i = vecs[i].pc; in_delayslot_i = vecs[i].ds; mem_addr_i = vecs[i].maddr;
            epc_i = vecs[i].epc; cp0_we_i = vecs[i].we; cp0_waddr_i = vecs[i].waddr;
            cp0_wdata_i = vecs[i].wdata;
            settle();
            chk_commit($sformatf("vec%0d", i), vecs[i].e_code, vecs[i].e_newpc, vecs[i].e_bad);
            chk($sformatf("vec%0d curpc", i), current_inst_addr_o, vecs[i].pc);
            chk($sformatf("vec%0d ds", i), {31'd0, is_in_delayslot_o}, {31'd0, vecs[i].ds});
            adv();
            clr_in();
            adv();
        end

        // ov held high: the block cycle must not re-commit it.
        clr_in(); inst_valid_i = 1'b1; ov_i = 1'b1; pc_i = 32'h8000_1000;
        settle(); chk_commit("ov first", 32'h0c, 32'hBFC0_0380, 32'h0);
        adv(); settle(); chk_commit("ov block", 32'h0, 32'h0, 32'h0);
        chk("ov block curpc", current_inst_addr_o, 32'h8000_1000);
        adv(); clr_in(); adv();

        // ri held under stall for three cycles, then released.
        clr_in(); inst_valid_i = 1'b1; ri_i = 1'b1; stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle(); chk_commit($sformatf("ri stall%0d", k), 32'h0, 32'h0, 32'h0);
            adv();
        end
        stall_i = 1'b0;
        settle(); chk_commit("ri release", 32'h0a, 32'hBFC0_0380, 32'h0);
        adv(); stall_i = 1'b1; settle(); chk("ri after stall", excepttype_o, 32'h0);
        adv(); stall_i = 1'b0; settle(); chk("ri after idle", excepttype_o, 32'h0a);
        adv(); clr_in(); adv();

        // Hardware interrupt on line 0: sync latency, bubbles, stall, then commit.
        clr_in(); status_i = 32'h0000_FF01; int_i = 6'h01;
        settle(); chk("sync t0", {26'd0, int_sync_o}, 32'h0);
        adv(); settle(); chk("sync t1", {26'd0, int_sync_o}, 32'h0);
        adv(); settle(); chk("sync t2", {26'd0, int_sync_o}, 32'h01);
        for (int k = 0; k < 3; k++) begin
            adv(); settle(); chk($sformatf("int bubble%0d", k), excepttype_o, 32'h0);
        end
        adv(); inst_valid_i = 1'b1; stall_i = 1'b1; pc_i = 32'h8000_7000;
        settle(); chk("int stalled", excepttype_o, 32'h0);
        adv(); stall_i = 1'b0;
        settle(); chk_commit("int take", 32'h01, 32'hBFC0_0380, 32'h0);
        adv(); settle(); chk("int block", excepttype_o, 32'h0);
        // Same-cycle MTC0 clearing IE masks the still-pending interrupt.
        adv(); cp0_we_i = 1'b1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'h0000_FF00;
        settle(); chk_commit("int masked", 32'h0, 32'h0, 32'h0);
        adv(); clr_in(); adv();
        inst_valid_i = 1'b1;
        settle(); chk("int unmasked", excepttype_o, 32'h01);
        adv(); clr_in(); int_i = 6'h00; status_i = 32'h0;
        for (int k = 0; k < 4; k++) adv();

        // Software interrupt raised purely through the Cause[9:8] bypass.
        status_i = 32'h0000_0301; cp0_we_i = 1'b1; cp0_waddr_i = 5'd13; cp0_wdata_i = 32'h0000_0100;
        settle(); chk("swint bubble", excepttype_o, 32'h0);
        adv(); inst_valid_i = 1'b1;
        settle(); chk("swint take", excepttype_o, 32'h01);
        adv(); clr_in(); status_i = 32'h0; adv();

        // Reset pulsed during the block cycle.
        clr_in(); inst_valid_i = 1'b1; ov_i = 1'b1; pc_i = 32'h8000_8000;
        settle(); chk("rstblk commit", excepttype_o, 32'h0c);
        adv(); rst = 1'b1;
        settle(); chk_commit("rstblk in rst", 32'h0, 32'h0, 32'h0);
        chk("rstblk curpc", current_inst_addr_o, 32'h0);
        adv(); rst = 1'b0;
        settle(); chk_commit("rstblk idle", 32'h0c, 32'hBFC0_0380, 32'h0);
        chk("rstblk curpc2", current_inst_addr_o, 32'h8000_8000);
        adv(); clr_in(); adv();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/except_unit.md
# except_unit

Memory-stage exception collector and dispatcher for the MIPS pipeline. It gathers per-instruction exception flags and external interrupt lines, resolves priority against live CP0 Status/Cause/EPC, and drives the commit interface into the CP0 register block. It also drives the pipeline-wide flush and the redirect PC. It is the producer of the CP0 block's exception-type, faulting-PC, delay-slot and bad-address inputs, and its hardware-interrupt input.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect PC for every exception other than eret.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- int_i  in  6  raw asynchronous hardware interrupt lines.
- stall_i  in  1  memory stage held by the sram-like bus; no commit while high.
- inst_valid_i  in  1  memory stage holds a real instruction, not a bubble.
- pc_i  in  32  PC of the memory-stage instruction.
- in_delayslot_i  in  1  instruction is in a branch delay slot.
- adel_if_i, ri_i, syscall_i, break_i, ov_i, adel_ld_i, ades_i, eret_i  in  1 each  exception flags carried down the pipe.
- mem_addr_i  in  32  data address of the load/store.
- status_i, cause_i, epc_i  in  32 each  current CP0 register values.
- cp0_we_i  in  1  MTC0 write in the writeback stage.
- cp0_waddr_i  in  5  target CP0 register number.
- cp0_wdata_i  in  32  value being written.
- int_sync_o  out  6  synchronized interrupt lines, feed CP0 Cause[15:10].
- excepttype_o  out  32  commit code to CP0; 0 = none.
- current_inst_addr_o  out  32  equals pc_i when committing.
- is_in_delayslot_o  out  1  equals in_delayslot_i when committing.
- bad_addr_o  out  32  faulting address.
- flush_o  out  1  kill IF..MEM and redirect.
- newpc_o  out  32  redirect target, valid with flush_o.

## Operation
- Bypass: status_eff/cause_eff/epc_eff use cp0_wdata_i when cp0_we_i and cp0_waddr_i = 12/13/14. Otherwise they use the CP0 inputs. For Cause, only bits [9:8] are bypassed.
- int_pend = |(cause_eff[15:8] & status_eff[15:8]) & status_eff[0] & ~status_eff[1].
- Interrupt latch: int_req register.
  - Set when int_pend.
  - Cleared on an interrupt commit, or when int_pend drops while not committing.
- commit_ok = state==IDLE & ~stall_i & inst_valid_i.
- Priority, highest first, with code:
  - interrupt (int_req): 0x01
  - adel_if: 0x04, bad_addr = pc_i
  - ri: 0x0a
  - syscall: 0x08
  - break: 0x09
  - ov: 0x0c
  - adel_ld: 0x04, bad_addr = mem_addr_i
  - ades: 0x05, bad_addr = mem_addr_i
  - eret: 0x0e
- On commit_ok with a selected code:
  - excepttype_o = code; flush_o = 1.
  - newpc_o = epc_eff for eret, else EXC_VECTOR.
  - current_inst_addr_o and is_in_delayslot_o are passed through from pc_i and in_delayslot_i.
- When there is no commit:
  - excepttype_o, flush_o, newpc_o and bad_addr_o are 0.
  - current_inst_addr_o and is_in_delayslot_o still pass through.
- FSM:
  - IDLE -> BLOCK on any commit.
  - BLOCK -> IDLE after exactly one cycle.
  - In BLOCK, no commit occurs, so the flushed slot cannot re-raise.
- An interrupt is never taken on a bubble or during a stall. int_req stays set until a valid, unstalled instruction arrives.

## Timing
- int_i -> int_sync_o: 2-flop synchronizer, 2 cycles.
- Cause IP updates in CP0 one cycle later, then int_req sets one cycle after that.
- Commit outputs are combinational in the commit cycle. CP0 captures them on the next edge.
- excepttype_o is nonzero for exactly one cycle per exception, even if stall_i toggles.
- Reset: int sync flops 0, int_req 0, state IDLE, all outputs 0.
- Reset asserted mid-BLOCK returns the FSM to IDLE.
- Simultaneous MTC0 to Status clearing IE and a pending interrupt: the bypass wins, so no interrupt is taken.
- Simultaneous eret and MTC0 EPC: newpc_o = cp0_wdata_i.

## Structure
- Shared package: CP0 register numbers (12/13/14), excepttype codes 0x01/0x04/0x05/0x08/0x09/0x0a/0x0c/0x0e, EXC_VECTOR default, Status bit positions IE=0, EXL=1, IM=[15:8].
- One sub-module: int_sync. It is a 6-bit two-flop synchronizer, parameterised by width, with synchronous reset.

## Test plan
- ov_i=1 with pc_i=0x80001000, delay slot 0, no stall:
  - excepttype_o=0x0c, flush_o=1, newpc_o=0xBFC00380 for one cycle.
  - The next cycle is BLOCK, with outputs 0 even though ov_i is still 1.
- adel_ld_i and ades_i both set, with mem_addr_i=0x80000003: code 0x04, bad_addr_o=0x80000003.
- ri_i set while stall_i=1 for 3 cycles, then low: excepttype_o stays 0 until the first unstalled cycle, then 0x0a once.
- Status=0x0000FF01, int_i[0] rises, CP0 model reflects IP2: int_req sets. With inst_valid_i=0 for 2 cycles, there is no commit. The first valid cycle commits code 0x01.
- eret_i with epc_i=0x80002000, and the same cycle MTC0 EPC=0x80003000: newpc_o=0x80003000, code 0x0e.
- Interrupt pending while MTC0 Status=0x0000FF00 in writeback: no commit. rst pulsed in BLOCK: the next cycle is IDLE with all outputs 0.
